// File: rtl/speed_pwm_driver.sv
// Speed-command PWM driver: clamps the 0..100 % command, samples it at PWM period
// boundaries and ramps the applied duty toward it in 1 % steps.
module speed_pwm_driver #(
  parameter int CLK_DIV    = 500,
  parameter int RAMP_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] speed_percent,
  input  logic       enable,
  output logic       pwm_out,
  output logic [6:0] duty_current,
  output logic       period_start,
  output logic       at_target
);

  localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(CLK_DIV - 1);
  localparam logic [RAMP_W-1:0] RAMP_MAX = RAMP_W'(RAMP_TICKS - 1);
  localparam logic [6:0]        SLOT_MAX = 7'd99;
  localparam logic [6:0]        DUTY_MAX = 7'd100;

  logic [PRE_W-1:0]  prescaler;
  logic [6:0]        slot;
  logic [RAMP_W-1:0] ramp_cnt;
  logic [RAMP_W-1:0] ramp_nxt;
  logic [6:0]        target_q;
  logic [6:0]        duty_nxt;
  logic [6:0]        tgt_in;
  logic              tick;
  logic              boundary;

  always_comb begin
    tick     = (prescaler == PRE_MAX);
    boundary = tick && (slot == SLOT_MAX);
    tgt_in   = (speed_percent > DUTY_MAX) ? DUTY_MAX : speed_percent;
  end

  // Disable wins over the boundary ramp and takes effect on any clock.
  always_comb begin
    duty_nxt = duty_current;
    ramp_nxt = ramp_cnt;
    if (!enable) begin
      duty_nxt = 7'd0;
      ramp_nxt = '0;
    end else if (boundary) begin
      if (duty_current == tgt_in) begin
        ramp_nxt = '0;
      end else if (ramp_cnt == RAMP_MAX) begin
        ramp_nxt = '0;
        duty_nxt = (duty_current < tgt_in) ? duty_current + 7'd1 : duty_current - 7'd1;
      end else begin
        ramp_nxt = ramp_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler    <= '0;
      slot         <= 7'd0;
      ramp_cnt     <= '0;
      target_q     <= 7'd0;
      duty_current <= 7'd0;
      period_start <= 1'b0;
      pwm_out      <= 1'b0;
    end else begin
      prescaler    <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        slot <= (slot == SLOT_MAX) ? 7'd0 : slot + 7'd1;
      end
      if (boundary) begin
        target_q <= tgt_in;
      end
      ramp_cnt     <= ramp_nxt;
      duty_current <= duty_nxt;
      period_start <= boundary;
      pwm_out      <= enable && (slot < duty_current);
    end
  end

  assign at_target = (duty_current == target_q);

endmodule

// File: tb/tb_speed_pwm_driver.sv
// Bench for speed_pwm_driver: table of steady-state ramp targets plus directed
// sequences for mid-period changes, enable drop, async reset and slow ramping.
module tb_speed_pwm_driver;

  logic       clk;
  logic       reset_n;
  logic [6:0] speed_percent;
  logic       enable;
  logic       pwm_out;
  logic [6:0] duty_current;
  logic       period_start;
  logic       at_target;

  logic       rst3_n;
  logic [6:0] speed3;
  logic       en3;
  logic       pwm3;
  logic [6:0] duty3;
  logic       ps3;
  logic       at3;

  int n_checks = 0;
  int n_fail   = 0;

  speed_pwm_driver #(.CLK_DIV(2), .RAMP_TICKS(1)) dut (
    .clk(clk), .reset_n(reset_n), .speed_percent(speed_percent), .enable(enable),
    .pwm_out(pwm_out), .duty_current(duty_current), .period_start(period_start),
    .at_target(at_target)
  );

  speed_pwm_driver #(.CLK_DIV(2), .RAMP_TICKS(3)) dut3 (
    .clk(clk), .reset_n(rst3_n), .speed_percent(speed3), .enable(en3),
    .pwm_out(pwm3), .duty_current(duty3), .period_start(ps3), .at_target(at3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic [6:0] speed;
    logic       en;
    logic [6:0] exp_duty;
    logic [7:0] exp_periods;
    logic [8:0] exp_high;
    logic       exp_at;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_duty(input logic [6:0] tgt, input int budget,
                           output int nb, output int ok);
    nb = 0;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (period_start) nb++;
      if (duty_current == tgt) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_ps(input int budget, output int ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (period_start) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic count_high(output int h);
    h = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pwm_out) h++;
    end
  endtask

  initial begin
    int nb;
    int ok;
    int h;
    int gap;
    int exp3;

    vecs[0] = '{7'd50,  1'b1, 7'd50,  8'd50,  9'd100, 1'b1};
    vecs[1] = '{7'd127, 1'b1, 7'd100, 8'd50,  9'd200, 1'b1};
    vecs[2] = '{7'd0,   1'b1, 7'd0,   8'd100, 9'd0,   1'b1};
    vecs[3] = '{7'd3,   1'b1, 7'd3,   8'd3,   9'd6,   1'b1};
    vecs[4] = '{7'd5,   1'b0, 7'd0,   8'd0,   9'd0,   1'b0};

    reset_n = 1'b0; rst3_n = 1'b0;
    speed_percent = 7'd0; enable = 1'b0;
    speed3 = 7'd0; en3 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pwm", pwm_out, 0);
    check("reset_duty", duty_current, 0);
    check("reset_at_target", at_target, 1);
    check("reset_period_start", period_start, 0);
    check("reset_duty3", duty3, 0);

    reset_n = 1'b1; rst3_n = 1'b1;
    speed3 = 7'd5; en3 = 1'b1;

    // Slow ramp: one 1 % step every third boundary.
    for (int n = 1; n <= 16; n++) begin
      ok = 0;
      for (int i = 0; i < 250; i++) begin
        @(negedge clk);
        if (ps3) begin
          ok = 1;
          break;
        end
      end
      check("ramp3_boundary_seen", ok, 1);
      exp3 = (n / 3 > 5) ? 5 : n / 3;
      check($sformatf("ramp3_duty_b%0d", n), duty3, exp3);
    end
    check("ramp3_at_target", at3, 1);
    en3 = 1'b0;

    for (int v = 0; v < 5; v++) begin
      speed_percent = vecs[v].speed;
      enable        = vecs[v].en;
      wait_duty(vecs[v].exp_duty, (int'(vecs[v].exp_periods) + 3) * 200, nb, ok);
      check($sformatf("vec%0d_reached", v), ok, 1);
      check($sformatf("vec%0d_boundaries", v), nb, int'(vecs[v].exp_periods));
      check($sformatf("vec%0d_at_target", v), at_target, int'(vecs[v].exp_at));
      @(negedge clk);
      count_high(h);
      check($sformatf("vec%0d_high_clk", v), h, int'(vecs[v].exp_high));
    end

    // Mid-period command change must not disturb the running period.
    speed_percent = 7'd30;
    enable = 1'b1;
    wait_duty(7'd30, 33 * 200, nb, ok);
    check("midchg_reach30", ok, 1);
    wait_ps(250, ok);
    check("midchg_align", ok, 1);
    h = 0;
    for (int k = 0; k < 200; k++) begin
      if (k == 80) speed_percent = 7'd70;
      if (pwm_out) h++;
      @(negedge clk);
    end
    check("midchg_high_clk", h, 60);
    check("midchg_period_start", period_start, 1);
    check("midchg_duty31", duty_current, 31);
    check("midchg_at_target", at_target, 0);

    // Enable drop clears duty within one clock; timebase keeps running.
    wait_duty(7'd40, 12 * 200, nb, ok);
    check("en_reach40", ok, 1);
    repeat (50) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("en_off_pwm", pwm_out, 0);
    check("en_off_duty", duty_current, 0);
    wait_ps(250, ok);
    check("en_off_ps1", ok, 1);
    gap = 0;
    ok = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      gap++;
      if (period_start) begin
        ok = 1;
        break;
      end
    end
    check("en_off_ps2", ok, 1);
    check("en_off_ps_spacing", gap, 200);
    enable = 1'b1;
    wait_ps(250, ok);
    check("en_on_ps", ok, 1);
    check("en_on_duty1", duty_current, 1);

    // Asynchronous reset in the middle of a ramp.
    wait_duty(7'd37, 40 * 200, nb, ok);
    check("rst_reach37", ok, 1);
    repeat (30) @(negedge clk);
    check("rst_pre_pwm", pwm_out, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_pwm", pwm_out, 0);
    check("rst_mid_duty", duty_current, 0);
    check("rst_mid_at_target", at_target, 1);
    check("rst_mid_period_start", period_start, 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
